// File: rtl/branch_pred_btb_pkg.sv
// ============================================================================
// Module      : branch_pred_btb_pkg
// Description : Shared definitions for the BTB next-PC predictor. This package
//               holds the default widths, the 2-bit counter encoding and the
//               saturating counter helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pred_btb_pkg;

   localparam int DBITS    = 32;
   localparam int INSTSIZE = 4;

   // 2-bit saturating counter states; bit 1 set means "predict taken"
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   // Write operations applied to one counter entry per cycle
   typedef enum logic [1:0] {
      CTR_HOLD = 2'b00,
      CTR_INC  = 2'b01,
      CTR_DEC  = 2'b10,
      CTR_LOAD = 2'b11
   } ctr_op_t;

   function automatic ctr_t sat_inc(input ctr_t c);
      return (c == ST) ? ST : ctr_t'(c + 2'b01);
   endfunction

   function automatic ctr_t sat_dec(input ctr_t c);
      return (c == SNT) ? SNT : ctr_t'(c - 2'b01);
   endfunction

endpackage

`default_nettype wire

// File: rtl/branch_pred_btb_sat_ctr_array.sv
// ============================================================================
// Module      : btb_sat_ctr_array
// Description : Counter RAM for the BTB. It has two combinational read ports
//               (fetch lookup and EX lookup) and one clocked write port that
//               does a saturating increment, a saturating decrement or a load
//               of the allocation value. The contents are not reset. The
//               valid bits in the top level gate every use of a counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_sat_ctr_array
   import branch_pred_btb_pkg::*;
#(
   parameter int   IDXBITS = 6,
   parameter ctr_t CTRINIT = WT
) (
   input  logic               clk,
   input  logic [IDXBITS-1:0] rd_idx_a,
   output ctr_t               rd_ctr_a,
   input  logic [IDXBITS-1:0] rd_idx_b,
   output ctr_t               rd_ctr_b,
   input  logic [IDXBITS-1:0] wr_idx,
   input  ctr_op_t            wr_op
);

   localparam int ENTRIES = 2**IDXBITS;

   ctr_t r_ctr [ENTRIES];

   assign rd_ctr_a = r_ctr[rd_idx_a];
   assign rd_ctr_b = r_ctr[rd_idx_b];

   // Apply the requested counter operation to the addressed entry
   always_ff @(posedge clk) begin
      case (wr_op)
         CTR_INC:  r_ctr[wr_idx] <= sat_inc(r_ctr[wr_idx]);
         CTR_DEC:  r_ctr[wr_idx] <= sat_dec(r_ctr[wr_idx]);
         CTR_LOAD: r_ctr[wr_idx] <= CTRINIT;
         default:  ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/branch_pred_btb.sv
// ============================================================================
// Module      : branch_pred_btb
// Description : Direct-mapped branch target buffer with a 2-bit counter per
//               entry. FE looks it up combinationally. EX resolves, computes
//               the redirect and trains the table on the clock edge.
//               Optional build macro BP_STATS_EN adds the stat_br and
//               stat_miss event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_pred_btb #(
   parameter int         DBITS    = branch_pred_btb_pkg::DBITS,
   parameter int         INSTSIZE = branch_pred_btb_pkg::INSTSIZE,
   parameter int         IDXBITS  = 6,
   parameter int         TAGBITS  = DBITS - IDXBITS - 2,
   parameter logic [1:0] CTRINIT  = 2'b10
) (
   input  logic             clk,
   input  logic             RESET_N,
   input  logic [DBITS-1:0] fe_pc,
   output logic [DBITS-1:0] pred_pc,
   output logic             pred_taken,
   input  logic             ex_valid,
   input  logic [DBITS-1:0] ex_pc,
   input  logic             ex_is_br,
   input  logic             ex_taken,
   input  logic [DBITS-1:0] ex_target,
   input  logic [DBITS-1:0] ex_pred_pc,
   output logic             ex_mispred,
   output logic [DBITS-1:0] ex_good_pc
`ifdef BP_STATS_EN
   ,
   output logic [31:0]      stat_br,
   output logic [31:0]      stat_miss
`endif
);

   import branch_pred_btb_pkg::*;

   localparam int ENTRIES = 2**IDXBITS;

   logic [ENTRIES-1:0] r_valid;
   logic [TAGBITS-1:0] r_tag [ENTRIES];
   logic [DBITS-1:0]   r_tgt [ENTRIES];

   logic [IDXBITS-1:0] w_fe_idx;
   logic [TAGBITS-1:0] w_fe_tag;
   logic [IDXBITS-1:0] w_ex_idx;
   logic [TAGBITS-1:0] w_ex_tag;
   ctr_t               w_fe_ctr;
   ctr_t               w_ex_ctr;
   logic               w_fe_hit;
   logic               w_ex_hit;
   logic               w_br_upd;
   logic               w_alloc;
   logic               w_train;
   logic               w_inval;
   ctr_op_t            w_ctr_op;

   assign w_fe_idx = fe_pc[IDXBITS+1:2];
   assign w_fe_tag = fe_pc[DBITS-1:IDXBITS+2];
   assign w_ex_idx = ex_pc[IDXBITS+1:2];
   assign w_ex_tag = ex_pc[DBITS-1:IDXBITS+2];

   btb_sat_ctr_array #(
      .IDXBITS (IDXBITS),
      .CTRINIT (ctr_t'(CTRINIT))
   ) u_ctr (
      .clk      (clk),
      .rd_idx_a (w_fe_idx),
      .rd_ctr_a (w_fe_ctr),
      .rd_idx_b (w_ex_idx),
      .rd_ctr_b (w_ex_ctr),
      .wr_idx   (w_ex_idx),
      .wr_op    (w_ctr_op)
   );

   // Fetch-side lookup: a valid entry with a matching tag and a taken counter redirects fetch
   always_comb begin
      w_fe_hit   = r_valid[w_fe_idx] && (r_tag[w_fe_idx] == w_fe_tag);
      pred_taken = w_fe_hit && w_fe_ctr[1];
      pred_pc    = pred_taken ? r_tgt[w_fe_idx] : fe_pc + DBITS'(INSTSIZE);
   end

   // Resolve in EX: every real instruction is checked, so stale hits on non-branches get corrected
   always_comb begin
      w_ex_hit   = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
      ex_good_pc = (ex_is_br && ex_taken) ? ex_target : ex_pc + DBITS'(INSTSIZE);
      ex_mispred = ex_valid && (ex_good_pc != ex_pred_pc);
      w_br_upd   = ex_valid && ex_is_br;
      w_alloc    = w_br_upd && !w_ex_hit && ex_taken;
      w_train    = w_br_upd && w_ex_hit;
      w_inval    = ex_valid && !ex_is_br && w_ex_hit && w_ex_ctr[1];
      w_ctr_op   = CTR_HOLD;
      if (w_alloc)
         w_ctr_op = CTR_LOAD;
      else if (w_train)
         w_ctr_op = ex_taken ? CTR_INC : CTR_DEC;
   end

   // Valid bits: set on allocation, cleared when a non-branch hit would have redirected
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N)
         r_valid <= '0;
      else if (w_alloc)
         r_valid[w_ex_idx] <= 1'b1;
      else if (w_inval)
         r_valid[w_ex_idx] <= 1'b0;
   end

   // Tag and target storage; a taken branch always refreshes the target
   always_ff @(posedge clk) begin
      if (w_alloc)
         r_tag[w_ex_idx] <= w_ex_tag;
      if (w_alloc || (w_train && ex_taken))
         r_tgt[w_ex_idx] <= ex_target;
   end

`ifdef BP_STATS_EN
   // Event counters for resolved branches and redirects, wrapping at 2**32
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         stat_br   <= '0;
         stat_miss <= '0;
      end else begin
         if (w_br_upd)
            stat_br <= stat_br + 32'd1;
         if (ex_mispred)
            stat_miss <= stat_miss + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_pred_btb.sv
// ============================================================================
// Module      : tb_branch_pred_btb
// Description : Directed self-checking bench for branch_pred_btb using the
//               default geometry (IDXBITS=6, idx=pc[7:2], tag=pc[31:8]).
//               The stats checks compile in when BP_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_pred_btb;

   logic        clk = 1'b0;
   logic        RESET_N;
   logic [31:0] fe_pc;
   logic [31:0] pred_pc;
   logic        pred_taken;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_is_br;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic [31:0] ex_pred_pc;
   logic        ex_mispred;
   logic [31:0] ex_good_pc;
`ifdef BP_STATS_EN
   logic [31:0] stat_br;
   logic [31:0] stat_miss;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_pred_btb dut (
      .clk        (clk),
      .RESET_N    (RESET_N),
      .fe_pc      (fe_pc),
      .pred_pc    (pred_pc),
      .pred_taken (pred_taken),
      .ex_valid   (ex_valid),
      .ex_pc      (ex_pc),
      .ex_is_br   (ex_is_br),
      .ex_taken   (ex_taken),
      .ex_target  (ex_target),
      .ex_pred_pc (ex_pred_pc),
      .ex_mispred (ex_mispred),
      .ex_good_pc (ex_good_pc)
`ifdef BP_STATS_EN
      ,
      .stat_br    (stat_br),
      .stat_miss  (stat_miss)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic [31:0] pc, input logic br,
                         input logic tk, input logic [31:0] tgt, input logic [31:0] ppc);
      ex_valid   = v;
      ex_pc      = pc;
      ex_is_br   = br;
      ex_taken   = tk;
      ex_target  = tgt;
      ex_pred_pc = ppc;
      #1;
   endtask

   task automatic idle_ex();
      set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      fe_pc = 32'h104;
      set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (pred_pc !== 32'h108 || pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL reset_lookup pred_pc=%h taken=%b required 00000108/0", pred_pc, pred_taken);
      end
      checks++;
      if (ex_mispred !== 1'b0) begin
         errors++;
         $display("FAIL reset_mispred actual=%b required 0", ex_mispred);
      end
      // a branch resolving while reset is held must not allocate
      set_ex(1'b1, 32'h104, 1'b1, 1'b1, 32'h140, 32'h108);
      step();
      RESET_N = 1'b1;
      idle_ex();
      fe_pc = 32'h104; #1;
      checks++;
      if (pred_pc !== 32'h108 || pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold_update pred_pc=%h taken=%b required 00000108/0", pred_pc, pred_taken);
      end
`ifdef BP_STATS_EN
      checks++;
      if (stat_br !== 32'd0 || stat_miss !== 32'd0) begin
         errors++;
         $display("FAIL reset_stats br=%0d miss=%0d required 0/0", stat_br, stat_miss);
      end
`endif
   endtask

   task automatic test_cold_miss();
      fe_pc = 32'h104; #1;
      checks++;
      if (pred_pc !== 32'h108 || pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL cold_lookup pred_pc=%h taken=%b required 00000108/0", pred_pc, pred_taken);
      end
      set_ex(1'b1, 32'h104, 1'b1, 1'b1, 32'h140, 32'h108);
      checks++;
      if (ex_mispred !== 1'b1 || ex_good_pc !== 32'h140) begin
         errors++;
         $display("FAIL cold_resolve mispred=%b good=%h required 1/00000140", ex_mispred, ex_good_pc);
      end
      step();
      idle_ex();
      checks++;
      if (pred_pc !== 32'h140 || pred_taken !== 1'b1) begin
         errors++;
         $display("FAIL cold_alloc pred_pc=%h taken=%b required 00000140/1", pred_pc, pred_taken);
      end
`ifdef BP_STATS_EN
      checks++;
      if (stat_br !== 32'd1 || stat_miss !== 32'd1) begin
         errors++;
         $display("FAIL cold_stats br=%0d miss=%0d required 1/1", stat_br, stat_miss);
      end
`endif
   endtask

   task automatic test_hysteresis();
      // counter 10 -> 11 -> 11 -> 11
      for (int i = 0; i < 3; i++) begin
         set_ex(1'b1, 32'h104, 1'b1, 1'b1, 32'h140, 32'h140);
         checks++;
         if (ex_mispred !== 1'b0) begin
            errors++;
            $display("FAIL hyst_train_%0d mispred=%b required 0", i, ex_mispred);
         end
         step();
      end
      idle_ex();
      fe_pc = 32'h104; #1;
      checks++;
      if (pred_pc !== 32'h140 || pred_taken !== 1'b1) begin
         errors++;
         $display("FAIL hyst_sat pred_pc=%h taken=%b required 00000140/1", pred_pc, pred_taken);
      end
      // 11 -> 10: still predicts taken
      set_ex(1'b1, 32'h104, 1'b1, 1'b0, 32'h140, 32'h140);
      checks++;
      if (ex_mispred !== 1'b1 || ex_good_pc !== 32'h108) begin
         errors++;
         $display("FAIL hyst_nt_resolve mispred=%b good=%h required 1/00000108", ex_mispred, ex_good_pc);
      end
      step();
      idle_ex();
      checks++;
      if (pred_pc !== 32'h140 || pred_taken !== 1'b1) begin
         errors++;
         $display("FAIL hyst_one_nt pred_pc=%h taken=%b required 00000140/1", pred_pc, pred_taken);
      end
      // 10 -> 01: now predicts fall-through
      set_ex(1'b1, 32'h104, 1'b1, 1'b0, 32'h140, 32'h140);
      step();
      idle_ex();
      checks++;
      if (pred_pc !== 32'h108 || pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL hyst_two_nt pred_pc=%h taken=%b required 00000108/0", pred_pc, pred_taken);
      end
      // 01 -> 00 -> 00, then taken 00 -> 01 keeps predicting not-taken
      repeat (2) begin
         set_ex(1'b1, 32'h104, 1'b1, 1'b0, 32'h140, 32'h108);
         step();
      end
      set_ex(1'b1, 32'h104, 1'b1, 1'b1, 32'h140, 32'h108);
      step();
      idle_ex();
      checks++;
      if (pred_pc !== 32'h108 || pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL hyst_floor pred_pc=%h taken=%b required 00000108/0", pred_pc, pred_taken);
      end
      // 01 -> 10
      set_ex(1'b1, 32'h104, 1'b1, 1'b1, 32'h140, 32'h108);
      step();
      idle_ex();
      checks++;
      if (pred_pc !== 32'h140 || pred_taken !== 1'b1) begin
         errors++;
         $display("FAIL hyst_recover pred_pc=%h taken=%b required 00000140/1", pred_pc, pred_taken);
      end
   endtask

   task automatic test_aliasing();
      fe_pc = 32'h204; #1;
      checks++;
      if (pred_pc !== 32'h208 || pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL alias_lookup pred_pc=%h taken=%b required 00000208/0", pred_pc, pred_taken);
      end
      set_ex(1'b1, 32'h204, 1'b1, 1'b1, 32'h300, 32'h208);
      checks++;
      if (ex_mispred !== 1'b1 || ex_good_pc !== 32'h300) begin
         errors++;
         $display("FAIL alias_resolve mispred=%b good=%h required 1/00000300", ex_mispred, ex_good_pc);
      end
      step();
      idle_ex();
      fe_pc = 32'h104; #1;
      checks++;
      if (pred_pc !== 32'h108 || pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL alias_evicted pred_pc=%h taken=%b required 00000108/0", pred_pc, pred_taken);
      end
      fe_pc = 32'h204; #1;
      checks++;
      if (pred_pc !== 32'h300 || pred_taken !== 1'b1) begin
         errors++;
         $display("FAIL alias_new pred_pc=%h taken=%b required 00000300/1", pred_pc, pred_taken);
      end
   endtask

   task automatic test_non_branch();
      set_ex(1'b1, 32'h110, 1'b0, 1'b0, 32'hDEAD_BEEC, 32'h114);
      checks++;
      if (ex_mispred !== 1'b0 || ex_good_pc !== 32'h114) begin
         errors++;
         $display("FAIL nonbr_ok mispred=%b good=%h required 0/00000114", ex_mispred, ex_good_pc);
      end
      step();
      idle_ex();
      fe_pc = 32'h110; #1;
      checks++;
      if (pred_pc !== 32'h114 || pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL nonbr_no_alloc pred_pc=%h taken=%b required 00000114/0", pred_pc, pred_taken);
      end
      // create a hit at 0x110, then resolve it as a non-branch
      set_ex(1'b1, 32'h110, 1'b1, 1'b1, 32'h200, 32'h114);
      step();
      idle_ex();
      checks++;
      if (pred_pc !== 32'h200 || pred_taken !== 1'b1) begin
         errors++;
         $display("FAIL nonbr_trained pred_pc=%h taken=%b required 00000200/1", pred_pc, pred_taken);
      end
      set_ex(1'b1, 32'h110, 1'b0, 1'b0, 32'h0, 32'h200);
      checks++;
      if (ex_mispred !== 1'b1 || ex_good_pc !== 32'h114) begin
         errors++;
         $display("FAIL nonbr_stale mispred=%b good=%h required 1/00000114", ex_mispred, ex_good_pc);
      end
      step();
      idle_ex();
      checks++;
      if (pred_pc !== 32'h114 || pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL nonbr_inval pred_pc=%h taken=%b required 00000114/0", pred_pc, pred_taken);
      end
      fe_pc = 32'h204; #1;
      checks++;
      if (pred_pc !== 32'h300 || pred_taken !== 1'b1) begin
         errors++;
         $display("FAIL nonbr_other_entry pred_pc=%h taken=%b required 00000300/1", pred_pc, pred_taken);
      end
   endtask

   task automatic test_bubble();
      set_ex(1'b0, 32'h204, 1'b1, 1'b1, 32'h500, 32'h999);
      checks++;
      if (ex_mispred !== 1'b0) begin
         errors++;
         $display("FAIL bubble_mispred actual=%b required 0", ex_mispred);
      end
      step();
      set_ex(1'b0, 32'h404, 1'b1, 1'b1, 32'h600, 32'h0);
      step();
      idle_ex();
      fe_pc = 32'h204; #1;
      checks++;
      if (pred_pc !== 32'h300 || pred_taken !== 1'b1) begin
         errors++;
         $display("FAIL bubble_no_update pred_pc=%h taken=%b required 00000300/1", pred_pc, pred_taken);
      end
   endtask

   task automatic test_back_to_back();
      fe_pc = 32'h120;
      set_ex(1'b1, 32'h120, 1'b1, 1'b1, 32'h180, 32'h124);
      checks++;
      if (pred_pc !== 32'h124 || pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_bypass pred_pc=%h taken=%b required 00000124/0", pred_pc, pred_taken);
      end
      step();
      set_ex(1'b1, 32'h130, 1'b1, 1'b1, 32'h1A0, 32'h134);
      checks++;
      if (pred_pc !== 32'h180 || pred_taken !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first pred_pc=%h taken=%b required 00000180/1", pred_pc, pred_taken);
      end
      step();
      idle_ex();
      fe_pc = 32'h130; #1;
      checks++;
      if (pred_pc !== 32'h1A0 || pred_taken !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second pred_pc=%h taken=%b required 000001a0/1", pred_pc, pred_taken);
      end
   endtask

   task automatic test_wrap();
      fe_pc = 32'hFFFF_FFFC;
      set_ex(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (pred_pc !== 32'h0 || pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL wrap_lookup pred_pc=%h taken=%b required 00000000/0", pred_pc, pred_taken);
      end
      checks++;
      if (ex_mispred !== 1'b0 || ex_good_pc !== 32'h0) begin
         errors++;
         $display("FAIL wrap_resolve mispred=%b good=%h required 0/00000000", ex_mispred, ex_good_pc);
      end
      step();
      idle_ex();
   endtask

   task automatic test_reset_mid();
      set_ex(1'b1, 32'h104, 1'b1, 1'b1, 32'h140, 32'h108);
      step();
      idle_ex();
      fe_pc = 32'h104; #1;
      checks++;
      if (pred_pc !== 32'h140 || pred_taken !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre pred_pc=%h taken=%b required 00000140/1", pred_pc, pred_taken);
      end
      // half-cycle low pulse that does not span a rising edge
      RESET_N = 1'b0;
      #4;
      RESET_N = 1'b1;
      #1;
      checks++;
      if (pred_pc !== 32'h108 || pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL rst_post pred_pc=%h taken=%b required 00000108/0", pred_pc, pred_taken);
      end
      fe_pc = 32'h130; #1;
      checks++;
      if (pred_pc !== 32'h134 || pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL rst_post_other pred_pc=%h taken=%b required 00000134/0", pred_pc, pred_taken);
      end
`ifdef BP_STATS_EN
      checks++;
      if (stat_br !== 32'd0 || stat_miss !== 32'd0) begin
         errors++;
         $display("FAIL rst_stats br=%0d miss=%0d required 0/0", stat_br, stat_miss);
      end
`endif
      step();
   endtask

   initial begin
      RESET_N = 1'b1;
      fe_pc   = 32'h0;
      ex_valid = 1'b0; ex_pc = 32'h0; ex_is_br = 1'b0; ex_taken = 1'b0;
      ex_target = 32'h0; ex_pred_pc = 32'h0;
      #2;
      RESET_N = 1'b0;
      test_reset();
      test_cold_miss();
      test_hysteresis();
      test_aliasing();
      test_non_branch();
      test_bubble();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/branch_pred_btb.md
Name: branch_pred_btb

Overview:
Parametrised next-PC predictor for the 5-stage pipeline. It replaces the fixed PC+INSTSIZE fetch prediction with a direct-mapped branch target buffer (BTB) holding a 2-bit saturating counter per entry. FE looks it up combinationally each cycle. EX resolves branches and jumps, trains the table, and receives the mispredict/redirect signals from this block.

Parameters:
DBITS, 32, data/PC width
INSTSIZE, 4, bytes per instruction; PC low bits log2(INSTSIZE) ignored
IDXBITS, 6, BTB index bits; ENTRIES = 2**IDXBITS
TAGBITS, 24, stored tag width = DBITS-IDXBITS-2 (full tag)
CTRINIT, 2'b10, counter value on allocation

Ports:
clk  in  1  pipeline clock
RESET_N  in  1  asynchronous, active-low reset
fe_pc  in  DBITS  PC being fetched
pred_pc  out  DBITS  predicted next PC for FE
pred_taken  out  1  lookup hit and counter[1]==1
ex_valid  in  1  EX holds a real (non-bubble) instruction
ex_pc  in  DBITS  PC of EX instruction
ex_is_br  in  1  EX instruction is a conditional branch or JAL
ex_taken  in  1  actual outcome (JAL is always 1)
ex_target  in  DBITS  actual taken target
ex_pred_pc  in  DBITS  pred_pc carried with the instruction from FE
ex_mispred  out  1  redirect FE this cycle
ex_good_pc  out  DBITS  correct next PC

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (RESET_N). While RESET_N=0, all ENTRIES valid bits clear. Tag, target and counter arrays are not reset.
- Index = pc[IDXBITS+1:2]. Tag = pc[DBITS-1:IDXBITS+2].
- Lookup is combinational, zero latency.
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_pc = pred_taken ? target[idx] : fe_pc+INSTSIZE.
- During reset, lookups miss, so pred_pc = fe_pc+INSTSIZE and pred_taken = 0.
- Resolve logic is combinational:
  - ex_good_pc = (ex_is_br && ex_taken) ? ex_target : ex_pc+INSTSIZE.
  - ex_mispred = ex_valid && (ex_good_pc != ex_pred_pc).
  - When ex_valid=0, ex_mispred = 0. ex_good_pc is don't-care in that case but must be deterministic.
  - Non-branches are also checked, so a stale or aliased BTB hit on a non-branch is corrected.
- Update happens on the posedge of clk when ex_valid && ex_is_br. idx and tag are taken from ex_pc.
  - Hit, taken: ctr = sat_inc(ctr) (11 stays 11); target = ex_target.
  - Hit, not taken: ctr = sat_dec(ctr) (00 stays 00); target unchanged.
  - Miss, taken: allocate (valid=1, tag, target=ex_target, ctr=CTRINIT). This evicts any aliasing entry.
  - Miss, not taken: no change.
- Update when ex_valid && !ex_is_br, and a hit with a taken prediction at ex_pc: invalidate that entry (valid=0).
- Updates become visible to a lookup on the following cycle. If a lookup and an update hit the same index in the same cycle, the lookup returns the old contents (no bypass).
- Reset asserted mid-training: on the next lookup every entry misses.
- Arithmetic: all PC additions are modulo 2**DBITS; wrap-around is not special-cased.

Optional Feature:
Macro: BP_STATS_EN.
- Defined: adds outputs stat_br (32 bits) and stat_miss (32 bits).
  - stat_br counts cycles with ex_valid && ex_is_br.
  - stat_miss counts cycles with ex_mispred.
  - Both are async-cleared to 0, wrap modulo 2**32, and are readable through the MMIO decoder.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds: DBITS, INSTSIZE, the 2-bit counter encoding (SNT=00, WNT=01, WT=10, ST=11), and the sat_inc and sat_dec functions.
- One sub-module, btb_sat_ctr_array, holds the counter RAM plus the saturating update logic. Tag/target storage and the valid vector stay in the top.

Test Plan:
- Cold miss:
  - Stimulus: fe_pc=0x104.
  - Required: pred_pc=0x108, pred_taken=0.
  - Then EX: ex_pc=0x104, br, taken, target 0x140, ex_pred_pc 0x108.
  - Required: ex_mispred=1, ex_good_pc=0x140. Next cycle fe_pc=0x104 gives pred_pc=0x140, pred_taken=1.
- Hysteresis:
  - Stimulus: train 0x104 taken 3 more times (ctr=11), then resolve not-taken once with ex_pred_pc=0x140.
  - Required: ex_mispred=1, ex_good_pc=0x108; lookup 0x104 still predicts 0x140. A second not-taken makes lookup give 0x108.
- Aliasing:
  - Stimulus: with 0x104 trained, fe_pc=0x204 (same idx 1, tag 2).
  - Required: pred_pc=0x208. Then resolve 0x204 taken to 0x300; lookup 0x104 now gives 0x108 (evicted).
- Non-branch check:
  - Stimulus: ex_valid=1, ex_is_br=0, ex_pc=0x110, ex_pred_pc=0x114.
  - Required: ex_mispred=0, no table change.
  - Stimulus: ex_pred_pc=0x200 on a hit entry.
  - Required: ex_mispred=1, ex_good_pc=0x114, entry invalidated.
- Bubble:
  - Stimulus: ex_valid=0 with arbitrary inputs.
  - Required: ex_mispred=0, no update.
- Reset:
  - Stimulus: after training 0x104→0x140, pulse RESET_N low for one half-cycle mid-stream.
  - Required: lookup 0x104 gives 0x108. With BP_STATS_EN, stat_br and stat_miss read 0.
